l1i_cache: RTL

L1I_CACHE -- requirements
Module: l1i_cache

---
 rtl/l1i_cache.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/l1i_cache.sv
// Direct-mapped L1 instruction cache.
// Lookups take one cycle. A miss requests the aligned line from L2 and fills
// it beat by beat. The requested word is returned after the fill completes.
module l1i_cache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              flush,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic              l2_req_valid,
  output logic [ADDR_W-1:0] l2_req_addr,
  input  logic              l2_req_ready,
  input  logic              l2_rsp_valid,
  input  logic [DATA_W-1:0] l2_rsp_data
);

  localparam int WB   = $clog2(DATA_W / 8);
  localparam int LW   = $clog2(LINE_WORDS);
  localparam int OFF  = WB + LW;
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - IDX - OFF;
  localparam int WI_W = (LW > 0) ? LW : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;
  logic [SETS-1:0]   valid_q;
  logic [TAG-1:0]    tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];
  logic [WI_W-1:0]   beat_cnt;
  logic              flush_pend;

  logic [IDX-1:0]    cap_set;
  logic [TAG-1:0]    cap_tag;
  logic [WI_W-1:0]   cap_word;
  logic              hit;
  logic              last_beat;
  logic              to_idle;

  // Fields of the captured fetch address. Byte-offset bits are dropped.
  assign cap_set   = cap_addr[OFF+IDX-1:OFF];
  assign cap_tag   = cap_addr[ADDR_W-1:OFF+IDX];
  assign cap_word  = WI_W'(cap_addr >> WB) & WI_W'(LINE_WORDS - 1);
  assign hit       = valid_q[cap_set] && (tag_q[cap_set] == cap_tag);
  assign last_beat = (beat_cnt == WI_W'(LINE_WORDS - 1));
  assign to_idle   = ((state == LOOKUP) && hit) || (state == RESP);

  // A flush in IDLE takes the cycle, so no request is accepted alongside it.
  assign req_ready = (state == IDLE) && !flush;

  // Tag and data storage; these need no reset because the valid bits guard them.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && l2_rsp_valid) begin
      data_q[cap_set][beat_cnt] <= l2_rsp_data;
      if (last_beat) begin
        tag_q[cap_set] <= cap_tag;
      end
    end
  end

  // Control FSM, valid bits, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cap_addr     <= '0;
      valid_q      <= '0;
      beat_cnt     <= '0;
      flush_pend   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      l2_req_valid <= 1'b0;
      l2_req_addr  <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            cap_addr <= req_addr;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            rsp_valid <= 1'b1;
            rsp_data  <= data_q[cap_set][cap_word];
            hit_cnt   <= hit_cnt + 32'd1;
            state     <= IDLE;
          end else begin
            miss_cnt     <= miss_cnt + 32'd1;
            l2_req_valid <= 1'b1;
            l2_req_addr  <= {cap_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            state        <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (l2_rsp_valid) begin
            if (last_beat) begin
              valid_q[cap_set] <= 1'b1;
              beat_cnt         <= '0;
              state            <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_data  <= data_q[cap_set][cap_word];
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if ((state != IDLE) && flush) begin
        flush_pend <= 1'b1;
      end
      if (to_idle && (flush_pend || flush)) begin
        valid_q    <= '0;
        flush_pend <= 1'b0;
      end
    end
  end

endmodule
